// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Per-register scoreboard of cycles-until-forwardable for in-flight
//   producers (ALU, load, multicycle MUL/DIV). It sits beside ID and raises
//   a single stall to IF/ID, with a per-cause breakdown and a saturating
//   stall-cycle counter.
// Ports
//   clk_i, reset_ni          clock, async active-low reset
//   id_valid_i               valid instruction in ID
//   id_rs_i/id_rt_i          source addresses
//   id_rs_use_i/id_rt_use_i  bit0 read in EX, bit1 read in ID (branch/jr)
//   id_wr_en_i/id_wr_addr_i  destination write enable / address
//   id_class_i               0 ALU, 1 load, 2 MUL/DIV, 3 treated as ALU
//   pipe_flush_i             flush all in-flight state
//   stat_clear_i             synchronous clear of stall_cycles_o
//   stall_o                  hold PC and IF/ID, bubble into ID/EX
//   stall_cause_o            bit0 RAW-EX, bit1 RAW-ID, bit2 WAW, bit3 MDU busy
//   mdu_busy_o               MUL/DIV unit occupied
//   stall_cycles_o           saturating count of stalled cycles

// One scoreboard entry: EX-use and ID-use wait counters for one register.
module hazard_reg_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] ld_ex_i,
  input  logic [CNT_W-1:0] ld_id_i,
  output logic [CNT_W-1:0] cnt_ex_o,
  output logic [CNT_W-1:0] cnt_id_o
);
  logic [CNT_W-1:0] ex_q, ex_d, id_q, id_d;

  always_comb begin
    ex_d = (ex_q != '0) ? ex_q - CNT_W'(1) : '0;
    id_d = (id_q != '0) ? id_q - CNT_W'(1) : '0;
    if (flush_i) begin
      ex_d = '0;
      id_d = '0;
    end else if (load_i) begin
      // a fresh issue overrides the decrement
      ex_d = ld_ex_i;
      id_d = ld_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ex_q <= '0;
      id_q <= '0;
    end else begin
      ex_q <= ex_d;
      id_q <= id_d;
    end
  end

  assign cnt_ex_o = ex_q;
  assign cnt_id_o = id_q;
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int LOAD_WAIT = 1,
  parameter int MUL_LAT   = 4,
  parameter int CNT_W     = 3,
  parameter int STAT_W    = 16
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs_i,
  input  logic [ADDR_W-1:0] id_rt_i,
  input  logic [1:0]        id_rs_use_i,
  input  logic [1:0]        id_rt_use_i,
  input  logic              id_wr_en_i,
  input  logic [ADDR_W-1:0] id_wr_addr_i,
  input  logic [1:0]        id_class_i,
  input  logic              pipe_flush_i,
  input  logic              stat_clear_i,
  output logic              stall_o,
  output logic [3:0]        stall_cause_o,
  output logic              mdu_busy_o,
  output logic [STAT_W-1:0] stall_cycles_o
);
  // id_wait peaks at MUL_LAT (or LOAD_WAIT+1); both must fit the counter.
  if (MUL_LAT < 2 || MUL_LAT > (2**CNT_W) - 1 || LOAD_WAIT + 1 > (2**CNT_W) - 1 ||
      NUM_REGS > 2**ADDR_W) begin : g_param_err
    $error("hazard_scoreboard: illegal MUL_LAT/LOAD_WAIT/CNT_W/NUM_REGS combination");
  end

  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_MUL  = 2'd2;

  function automatic logic [CNT_W-1:0] ex_wait_f(input logic [1:0] cls);
    case (cls)
      CLS_LOAD: ex_wait_f = CNT_W'(LOAD_WAIT);
      CLS_MUL:  ex_wait_f = CNT_W'(MUL_LAT - 1);
      default:  ex_wait_f = '0;
    endcase
  endfunction

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_ex, cnt_id;
  logic [CNT_W-1:0]  mdu_cnt_q, mdu_cnt_d;
  logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  ex_wait, id_wait, wa_cnt;
  logic rs_ex_nz, rs_id_nz, rt_ex_nz, rt_id_nz;
  logic raw_ex, raw_id, waw, mdu_hz;
  logic [3:0] cause;
  logic stall, issue;

  assign ex_wait = ex_wait_f(id_class_i);
  assign id_wait = ex_wait + CNT_W'(1);

  // r0 is hardwired zero; it never has a producer in flight
  assign cnt_ex[0] = '0;
  assign cnt_id[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_reg_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .flush_i  (pipe_flush_i),
      .load_i   (issue && id_wr_en_i && id_wr_addr_i == ADDR_W'(r)),
      .ld_ex_i  (ex_wait),
      .ld_id_i  (id_wait),
      .cnt_ex_o (cnt_ex[r]),
      .cnt_id_o (cnt_id[r])
    );
  end

  // Address lookup as a compare loop starting at 1: r0 and addresses beyond
  // NUM_REGS simply never match and so never hazard.
  always_comb begin
    rs_ex_nz = 1'b0;
    rs_id_nz = 1'b0;
    rt_ex_nz = 1'b0;
    rt_id_nz = 1'b0;
    wa_cnt   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (id_rs_i == ADDR_W'(r)) begin
        rs_ex_nz = |cnt_ex[r];
        rs_id_nz = |cnt_id[r];
      end
      if (id_rt_i == ADDR_W'(r)) begin
        rt_ex_nz = |cnt_ex[r];
        rt_id_nz = |cnt_id[r];
      end
      if (id_wr_addr_i == ADDR_W'(r)) wa_cnt = cnt_ex[r];
    end
  end

  assign raw_ex = (id_rs_use_i[0] & rs_ex_nz) | (id_rt_use_i[0] & rt_ex_nz);
  assign raw_id = (id_rs_use_i[1] & rs_id_nz) | (id_rt_use_i[1] & rt_id_nz);
  // A newer write may only retire no earlier than the pending one.
  assign waw    = id_wr_en_i & (id_wr_addr_i != '0) & (wa_cnt > ex_wait);
  assign mdu_hz = (id_class_i == CLS_MUL) & (mdu_cnt_q != '0);

  assign cause = id_valid_i ? {mdu_hz, waw, raw_id, raw_ex} : 4'b0;
  assign stall = (|cause) & ~pipe_flush_i;
  assign issue = id_valid_i & ~stall & ~pipe_flush_i;

  always_comb begin
    mdu_cnt_d = (mdu_cnt_q != '0) ? mdu_cnt_q - CNT_W'(1) : '0;
    if (pipe_flush_i)                       mdu_cnt_d = '0;
    else if (issue && id_class_i == CLS_MUL) mdu_cnt_d = CNT_W'(MUL_LAT - 1);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stat_clear_i)                     stall_cycles_d = '0;
    else if (stall && !(&stall_cycles_q)) stall_cycles_d = stall_cycles_q + STAT_W'(1);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      mdu_cnt_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      mdu_cnt_q      <= mdu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_o        = stall;
  assign stall_cause_o  = stall ? cause : 4'b0;
  assign mdu_busy_o     = (mdu_cnt_q != '0);
  assign stall_cycles_o = stall_cycles_q;
endmodule
